// File: rtl/jk_excite_driver.sv
// jk_excite_driver
//   Drives a bank of WIDTH JK flip-flops toward a requested Q pattern. For one
//   cycle it computes the J/K excitation from the live Q feedback and the target.
//   It then checks the feedback and re-drives up to MAX_RETRY more times. Each
//   request ends with a one-cycle done or err pulse.
//
//   Build option: JK_TOGGLE_EN
//     defined   -> differing bits are driven J=1,K=1 (toggle)
//     undefined -> differing bits are driven J=target,K=~target (set/reset)
//
// Ports
//   clk        clock, all state on posedge
//   R          synchronous active-high reset, wins over accept
//   tgt_valid  requester has a target on tgt_data
//   tgt_data   target Q pattern
//   tgt_ready  driver idle, a target is accepted on this edge if tgt_valid
//   q_fb       Q feedback from the bank
//   J, K       registered excitation, all-zero except during DRIVE
//   busy       state != IDLE
//   done       one-cycle pulse: bank matched the target
//   err        one-cycle pulse: bank still mismatched after all retries

// Per-bit excitation. Matching bits hold (J=K=0).
module jk_excite_lane (
  input  logic q,
  input  logic t,
  output logic j,
  output logic k
);
  logic diff;
  assign diff = q ^ t;
`ifdef JK_TOGGLE_EN
  assign j = diff;
  assign k = diff;
`else
  assign j = diff & t;
  assign k = diff & ~t;
`endif
endmodule

module jk_excite_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             R,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_q;
  logic [RW-1:0]    retry;
  logic [WIDTH-1:0] exc_tgt;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic             accept;

  assign tgt_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = tgt_valid & tgt_ready;

  // On accept the target is not yet latched, so excite from tgt_data directly.
  // On a retry (from CHECK) use the latched copy.
  assign exc_tgt = (state == IDLE) ? tgt_data : tgt_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    jk_excite_lane u_lane (
      .q (q_fb[i]),
      .t (exc_tgt[i]),
      .j (j_nxt[i]),
      .k (k_nxt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state <= IDLE;
      tgt_q <= '0;
      retry <= '0;
      J     <= '0;
      K     <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      // Pulses last only the cycle after CHECK.
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tgt_q <= tgt_data;
            retry <= '0;
            J     <= j_nxt;
            K     <= k_nxt;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          // One cycle of excitation, then let the bank hold while we check.
          J     <= '0;
          K     <= '0;
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == tgt_q) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry < RMAX) begin
            retry <= retry + RW'(1);
            J     <= j_nxt;
            K     <= k_nxt;
            state <= DRIVE;
          end else begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          J     <= '0;
          K     <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
